// File: rtl/ro_puf_array.sv
// -----------------------------------------------------------------------------
// ro_puf_array
//
// Multi-channel ring-oscillator PUF controller. It enables a bank of NUM_RO
// external ring oscillators for a fixed window of WINDOW clk cycles and counts
// the rising edges of each one. It then walks RESP_W neighbouring pairs,
// starting at the challenge index, and builds one response bit per pair:
// bit k is set when oscillator (base+k) ran faster than oscillator (base+k+1).
//
// Optional feature macro: RO_PUF_TIE_MASK_EN
//   When it is defined, the block gains parameter THRESH and output resp_mask.
//   resp_mask flags pairs whose counts differ by less than THRESH, because
//   those response bits are unreliable.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   start      in   single-cycle request, sampled only while idle
//   challenge  in   base oscillator index, latched together with start
//   ro_en      out  enable to every oscillator (all bits equal)
//   ro_in      in   raw oscillator outputs, asynchronous to clk
//   busy       out  high whenever the controller is not idle
//   done       out  one-cycle pulse when the response is valid
//   response   out  response bits, held until the next accepted start
//   resp_mask  out  unreliable-bit flags (only with RO_PUF_TIE_MASK_EN)
// -----------------------------------------------------------------------------
module ro_puf_array #(
   parameter int unsigned NUM_RO = 8,     // power of two, 2..64
   parameter int unsigned CNT_W  = 16,    // per-channel edge-counter width
   parameter int unsigned WINDOW = 1024,  // counting window in clk cycles
   parameter int unsigned RESP_W = 8      // response bits, 1..NUM_RO
`ifdef RO_PUF_TIE_MASK_EN
   ,
   parameter int unsigned THRESH = 4      // minimum reliable count difference
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(NUM_RO)-1:0]  challenge,
   output logic [NUM_RO-1:0]          ro_en,
   input  logic [NUM_RO-1:0]          ro_in,
   output logic                       busy,
   output logic                       done,
   output logic [RESP_W-1:0]          response
`ifdef RO_PUF_TIE_MASK_EN
   ,
   output logic [RESP_W-1:0]          resp_mask
`endif
);

   // --------------------------------------------------------------------------
   // Derived widths
   // --------------------------------------------------------------------------
   localparam int unsigned IDX_W = $clog2(NUM_RO);
   localparam int unsigned K_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
   localparam int unsigned T_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   // --------------------------------------------------------------------------
   // FSM encoding
   // --------------------------------------------------------------------------
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETTLE  = 3'd1;
   localparam logic [2:0] S_COUNT   = 3'd2;
   localparam logic [2:0] S_COMPARE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [2:0]        state_q,  state_d;
   logic [T_W-1:0]    timer_q,  timer_d;   // SETTLE and COUNT cycle counter
   logic [K_W-1:0]    k_q,      k_d;       // COMPARE step index
   logic [IDX_W-1:0]  base_q,   base_d;    // latched challenge

   logic              ro_en_q;
   logic              busy_q;
   logic              done_q;
   logic [RESP_W-1:0] response_q;

   // Synchroniser chain and edge-history flop per channel
   logic [NUM_RO-1:0] sync1_q;
   logic [NUM_RO-1:0] sync2_q;
   logic [NUM_RO-1:0] hist_q;
   logic [NUM_RO-1:0] rise;

   logic [CNT_W-1:0]  cnt_q [NUM_RO];

   logic              start_acc;   // start accepted this cycle
   logic              count_en;    // edges are counted this cycle

   // Pair selection for the current COMPARE step
   logic [IDX_W-1:0]  idx_a;
   logic [IDX_W-1:0]  idx_b;
   logic [CNT_W-1:0]  cnt_a;
   logic [CNT_W-1:0]  cnt_b;
   logic              a_gt_b;

   // --------------------------------------------------------------------------
   // Oscillator input synchronisers and rising-edge detection
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every flop in a clocked block is written with <=, so each
      // register samples the value its neighbour held before the edge; a
      // blocking '=' here would collapse the three stages into one.
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         hist_q  <= '0;
      end else begin
         sync1_q <= ro_in;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~hist_q;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   assign start_acc = (state_q == S_IDLE) && start;
   assign count_en  = (state_q == S_COUNT);

   always_comb begin
      // NOTE: every signal assigned below gets its hold value first, so no
      // path through the case leaves it unassigned and no latch is inferred.
      state_d = state_q;
      timer_d = timer_q;
      k_d     = k_q;
      base_d  = base_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = challenge;
               timer_d = '0;
               state_d = S_SETTLE;
            end
         end

         // Two cycles with the oscillators running but nothing counted, so
         // the synchronisers hold live data before the window opens.
         S_SETTLE: begin
            if (timer_q == T_W'(1)) begin
               timer_d = '0;
               state_d = S_COUNT;
            end else begin
               timer_d = timer_q + T_W'(1);
            end
         end

         S_COUNT: begin
            if (timer_q == T_W'(WINDOW - 1)) begin
               timer_d = '0;
               k_d     = '0;
               state_d = S_COMPARE;
            end else begin
               timer_d = timer_q + T_W'(1);
            end
         end

         S_COMPARE: begin
            if (k_q == K_W'(RESP_W - 1)) begin
               k_d     = '0;
               state_d = S_DONE;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM registers. The outputs are decoded from the next state and
   // registered, so ro_en/busy/done change exactly with the state and never
   // glitch on the oscillator enables.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         k_q     <= '0;
         base_q  <= '0;
         ro_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         k_q     <= k_d;
         base_q  <= base_d;
         ro_en_q <= (state_d == S_SETTLE) || (state_d == S_COUNT);
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   // --------------------------------------------------------------------------
   // Saturating per-channel edge counters
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the counter array is a handful of flops rather than a RAM, so it
      // takes the asynchronous reset like any other register; a real memory
      // macro would have no reset and would be cleared by start instead.
      if (rst) begin
         for (int i = 0; i < NUM_RO; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (start_acc) begin
         for (int i = 0; i < NUM_RO; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (count_en) begin
         for (int i = 0; i < NUM_RO; i++) begin
            // Hold at all-ones so a very fast oscillator never wraps and
            // suddenly looks like the slowest one.
            if (rise[i] && (cnt_q[i] != '1)) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Pair comparison. Index arithmetic is IDX_W bits wide, so stepping past
   // NUM_RO-1 wraps to 0 by truncation (NUM_RO is a power of two).
   // --------------------------------------------------------------------------
   assign idx_a  = base_q + IDX_W'(k_q);
   assign idx_b  = idx_a + IDX_W'(1);
   assign cnt_a  = cnt_q[idx_a];
   assign cnt_b  = cnt_q[idx_b];
   assign a_gt_b = (cnt_a > cnt_b);   // strict: a tie yields 0

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         response_q <= '0;
      end else if (start_acc) begin
         response_q <= '0;
      end else if (state_q == S_COMPARE) begin
         response_q[k_q] <= a_gt_b;
      end
   end

`ifdef RO_PUF_TIE_MASK_EN
   // --------------------------------------------------------------------------
   // Unreliable-bit mask: a pair whose counts are within THRESH of each other
   // may flip between evaluations, so its response bit is flagged.
   // --------------------------------------------------------------------------
   logic [CNT_W-1:0]  cnt_diff;
   logic              near_tie;
   logic [RESP_W-1:0] resp_mask_q;

   assign cnt_diff = a_gt_b ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
   assign near_tie = (32'(cnt_diff) < THRESH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_mask_q <= '0;
      end else if (start_acc) begin
         resp_mask_q <= '0;
      end else if (state_q == S_COMPARE) begin
         resp_mask_q[k_q] <= near_tie;
      end
   end

   assign resp_mask = resp_mask_q;
`endif

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign ro_en    = {NUM_RO{ro_en_q}};
   assign busy     = busy_q;
   assign done     = done_q;
   assign response = response_q;

endmodule

// File: tb/tb_ro_puf_array.sv
// -----------------------------------------------------------------------------
// tb_ro_puf_array
//
// Directed bench for ro_puf_array with NUM_RO=4, CNT_W=16, WINDOW=64, RESP_W=4.
// A second instance with CNT_W=4 sees a channel-0 oscillator toggling every
// clk cycle, exercising counter saturation.
//
// Cycle numbering: the rising edge that samples start is edge T; the cycle
// that follows it is cycle T+1. Outputs are sampled on falling edges, and the
// n-th falling edge after T lies inside cycle T+n.
//
// Oscillator model: ro_in[i] toggles every i+2 clk cycles, so over the 64-cycle
// window channels 0..3 see about 16 / 10-11 / 8 / 6-7 rising edges.
// -----------------------------------------------------------------------------
module tb_ro_puf_array;

   localparam int unsigned NUM_RO = 4;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WINDOW = 64;
   localparam int unsigned RESP_W = 4;

   logic              clk;
   logic              rst;
   logic              start;
   logic [1:0]        challenge;
   logic [3:0]        ro_in;
   logic [3:0]        ro_en;
   logic              busy;
   logic              done;
   logic [3:0]        response;

   logic              ro_fast;
   logic [3:0]        ro_in_s;
   logic [3:0]        ro_en_s;
   logic              busy_s;
   logic              done_s;
   logic [3:0]        response_s;
`ifdef RO_PUF_TIE_MASK_EN
   logic [3:0]        resp_mask;
   logic [3:0]        resp_mask_s;
`endif

   logic              tie_mode;   // drive ro_in[2] as a copy of ro_in[1]

   int                vec_cnt;
   int                err_cnt;

   ro_puf_array #(
      .NUM_RO (NUM_RO),
      .CNT_W  (CNT_W),
      .WINDOW (WINDOW),
      .RESP_W (RESP_W)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .challenge (challenge),
      .ro_en     (ro_en),
      .ro_in     (ro_in),
      .busy      (busy),
      .done      (done),
      .response  (response)
`ifdef RO_PUF_TIE_MASK_EN
      ,
      .resp_mask (resp_mask)
`endif
   );

   ro_puf_array #(
      .NUM_RO (NUM_RO),
      .CNT_W  (4),
      .WINDOW (WINDOW),
      .RESP_W (RESP_W)
   ) u_dut_sat (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .challenge (challenge),
      .ro_en     (ro_en_s),
      .ro_in     (ro_in_s),
      .busy      (busy_s),
      .done      (done_s),
      .response  (response_s)
`ifdef RO_PUF_TIE_MASK_EN
      ,
      .resp_mask (resp_mask_s)
`endif
   );

   assign ro_in_s = {ro_in[3:1], ro_fast};

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oscillator stimulus, updated shortly after each rising edge
   initial begin
      int         div [4];
      logic [3:0] g;
      g       = '0;
      ro_fast = 1'b0;
      ro_in   = '0;
      for (int i = 0; i < 4; i++) div[i] = 0;
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < 4; i++) begin
            div[i]++;
            if (div[i] == i + 2) begin
               div[i] = 0;
               g[i]   = ~g[i];
            end
         end
         ro_fast = ~ro_fast;
         ro_in   = {g[3], (tie_mode ? g[1] : g[2]), g[1], g[0]};
      end
   end

   // --------------------------------------------------------------------------
   // One request: start is presented for the cycle ending at edge T, then the
   // run is observed for 90 cycles. Optionally a second start is pulsed at
   // cycle resend_at with a different challenge.
   // --------------------------------------------------------------------------
   task automatic run_req(input logic [1:0] chal, input int resend_at,
                          output int done_at, output int done_cnt,
                          output int en_cnt, output int done_at_s,
                          output logic busy_after);
      done_at    = 0;
      done_cnt   = 0;
      en_cnt     = 0;
      done_at_s  = 0;
      busy_after = 1'bx;
      @(negedge clk);
      start     = 1'b1;
      challenge = chal;
      for (int n = 1; n <= 90; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (resend_at != 0 && n == resend_at) begin
            start     = 1'b1;
            challenge = ~chal;
         end
         if (resend_at != 0 && n == resend_at + 1) start = 1'b0;
         if (done_at != 0 && n == done_at + 1) busy_after = busy;
         if (done === 1'b1 && done_at == 0) done_at = n;
         if (done_s === 1'b1 && done_at_s == 0) done_at_s = n;
         if (done === 1'b1) done_cnt++;
         if (ro_en === 4'hF) en_cnt++;
      end
   endtask

   // --------------------------------------------------------------------------
   task automatic test_reset();
      rst       = 1'b1;
      start     = 1'b0;
      challenge = '0;
      tie_mode  = 1'b0;
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (ro_en !== 4'h0) begin
         err_cnt++;
         $display("FAIL reset_ro_en: got %0h expected 0", ro_en);
      end
      vec_cnt++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_busy_done: got busy=%0b done=%0b expected 0/0", busy, done);
      end
      vec_cnt++;
      if (response !== 4'h0) begin
         err_cnt++;
         $display("FAIL reset_response: got %0h expected 0", response);
      end
`ifdef RO_PUF_TIE_MASK_EN
      vec_cnt++;
      if (resp_mask !== 4'h0) begin
         err_cnt++;
         $display("FAIL reset_resp_mask: got %0h expected 0", resp_mask);
      end
`endif
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (busy !== 1'b0 || ro_en !== 4'h0) begin
         err_cnt++;
         $display("FAIL idle_after_reset: got busy=%0b ro_en=%0h expected 0/0", busy, ro_en);
      end
   endtask

   // challenge 0: pairs (0,1),(1,2),(2,3),(3,0) -> 1,1,1,0
   task automatic test_basic();
      int   d_at, d_cnt, e_cnt, d_at_s;
      logic b_after;
      run_req(2'd0, 0, d_at, d_cnt, e_cnt, d_at_s, b_after);
      vec_cnt++;
      if (d_at !== 71) begin
         err_cnt++;
         $display("FAIL basic_latency: got %0d expected 71", d_at);
      end
      vec_cnt++;
      if (d_cnt !== 1) begin
         err_cnt++;
         $display("FAIL basic_done_count: got %0d expected 1", d_cnt);
      end
      vec_cnt++;
      if (e_cnt !== 66) begin
         err_cnt++;
         $display("FAIL basic_ro_en_cycles: got %0d expected 66", e_cnt);
      end
      vec_cnt++;
      if (b_after !== 1'b0) begin
         err_cnt++;
         $display("FAIL basic_busy_after_done: got %0b expected 0", b_after);
      end
      vec_cnt++;
      if (response !== 4'b0111) begin
         err_cnt++;
         $display("FAIL basic_response: got %b expected 0111", response);
      end
   endtask

   // challenge 3: pairs (3,0),(0,1),(1,2),(2,3) -> 0,1,1,1
   task automatic test_challenge_wrap();
      int   d_at, d_cnt, e_cnt, d_at_s;
      logic b_after;
      run_req(2'd3, 0, d_at, d_cnt, e_cnt, d_at_s, b_after);
      vec_cnt++;
      if (response !== 4'b1110) begin
         err_cnt++;
         $display("FAIL wrap_response: got %b expected 1110", response);
      end
      vec_cnt++;
      if (d_at !== 71) begin
         err_cnt++;
         $display("FAIL wrap_latency: got %0d expected 71", d_at);
      end
   endtask

   // Channel 0 makes exactly 32 edges in the window; a 4-bit counter must hold
   // at 15, which still beats channel 1 (10-11). A wrapping counter would read
   // 0 and flip bits 0 and 3. Expected response: 0111.
   task automatic test_saturation();
      int   d_at, d_cnt, e_cnt, d_at_s;
      logic b_after;
      run_req(2'd0, 0, d_at, d_cnt, e_cnt, d_at_s, b_after);
      vec_cnt++;
      if (response_s !== 4'b0111) begin
         err_cnt++;
         $display("FAIL sat_response: got %b expected 0111", response_s);
      end
      vec_cnt++;
      if (d_at_s !== 71) begin
         err_cnt++;
         $display("FAIL sat_latency: got %0d expected 71", d_at_s);
      end
   endtask

   // ro_in[2] copies ro_in[1]; challenge 1: pairs (1,2) tie, (2,3), (3,0), (0,1)
   // -> response 0,1,0,1 ; mask bit 0 set, bits 2 and 3 clear (far apart).
   task automatic test_tie();
      int   d_at, d_cnt, e_cnt, d_at_s;
      logic b_after;
      tie_mode = 1'b1;
      repeat (20) @(negedge clk);
      run_req(2'd1, 0, d_at, d_cnt, e_cnt, d_at_s, b_after);
      tie_mode = 1'b0;
      vec_cnt++;
      if (response !== 4'b1010) begin
         err_cnt++;
         $display("FAIL tie_response: got %b expected 1010", response);
      end
`ifdef RO_PUF_TIE_MASK_EN
      vec_cnt++;
      if (resp_mask[0] !== 1'b1) begin
         err_cnt++;
         $display("FAIL tie_mask_bit0: got %b expected 1", resp_mask[0]);
      end
      vec_cnt++;
      if (resp_mask[3:2] !== 2'b00) begin
         err_cnt++;
         $display("FAIL tie_mask_separated: got %b expected 00", resp_mask[3:2]);
      end
`endif
      repeat (20) @(negedge clk);
   endtask

   // A second start 10 cycles in (challenge 3) must be ignored entirely.
   task automatic test_ignore_restart();
      int   d_at, d_cnt, e_cnt, d_at_s;
      logic b_after;
      run_req(2'd0, 10, d_at, d_cnt, e_cnt, d_at_s, b_after);
      vec_cnt++;
      if (d_at !== 71) begin
         err_cnt++;
         $display("FAIL ignore_latency: got %0d expected 71", d_at);
      end
      vec_cnt++;
      if (d_cnt !== 1) begin
         err_cnt++;
         $display("FAIL ignore_done_count: got %0d expected 1", d_cnt);
      end
      vec_cnt++;
      if (response !== 4'b0111) begin
         err_cnt++;
         $display("FAIL ignore_response: got %b expected 0111", response);
      end
   endtask

   // Reset during COUNT aborts at once; no done follows; next request completes.
   task automatic test_reset_abort();
      int   d_at, d_cnt, e_cnt, d_at_s;
      int   stray;
      logic b_after;
      @(negedge clk);
      start     = 1'b1;
      challenge = 2'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      vec_cnt++;
      if (busy !== 1'b1 || ro_en !== 4'hF) begin
         err_cnt++;
         $display("FAIL abort_precondition: got busy=%0b ro_en=%0h expected 1/f", busy, ro_en);
      end
      rst = 1'b1;
      #1;
      vec_cnt++;
      if (ro_en !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
         err_cnt++;
         $display("FAIL abort_outputs: got ro_en=%0h busy=%0b done=%0b expected 0/0/0",
                  ro_en, busy, done);
      end
      vec_cnt++;
      if (response !== 4'h0) begin
         err_cnt++;
         $display("FAIL abort_response: got %0h expected 0", response);
      end
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      stray = 0;
      for (int n = 0; n < 90; n++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      vec_cnt++;
      if (stray !== 0) begin
         err_cnt++;
         $display("FAIL abort_no_done: got %0d active cycles expected 0", stray);
      end
      run_req(2'd0, 0, d_at, d_cnt, e_cnt, d_at_s, b_after);
      vec_cnt++;
      if (d_at !== 71 || response !== 4'b0111) begin
         err_cnt++;
         $display("FAIL abort_recover: got done_at=%0d response=%b expected 71/0111",
                  d_at, response);
      end
   endtask

   // --------------------------------------------------------------------------
   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_basic();
      test_challenge_wrap();
      test_saturation();
      test_tie();
      test_ignore_restart();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/ro_puf_array.md
# ro_puf_array

Parametrised multi-channel ring-oscillator PUF controller, successor to the fixed four-oscillator ring-oscillator cells. It enables a bank of NUM_RO external ring oscillators for a fixed measurement window and counts each oscillator's rising edges. It then compares neighbouring pairs selected by a challenge to produce a RESP_W-bit response. It sits between the oscillator bank and the PUF readout/key-generation logic.

## Interface
- NUM_RO, 8: number of oscillator channels; power of two, 2..64
- CNT_W, 16: per-channel edge-counter width
- WINDOW, 1024: measurement window length in clk cycles, ≥ 1
- RESP_W, 8: response bits per challenge, 1..NUM_RO
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- challenge  in  log2(NUM_RO)  base oscillator index, sampled with start
- ro_en  out  NUM_RO  enable to every oscillator (all bits equal)
- ro_in  in  NUM_RO  raw oscillator outputs, asynchronous to clk
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when response is valid
- response  out  RESP_W  result, held until the next accepted start
- resp_mask  out  RESP_W  unreliable-bit flags (present only with RO_PUF_TIE_MASK_EN)

## Operation
- Each ro_in bit passes through a 2-flop synchroniser plus one history flop. A rising edge is synchronised-stage-2 high while the history flop is low.
- FSM states: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE: ro_en = 0. start = 1 latches challenge into base, clears all counters, and moves to SETTLE. start is ignored in every other state.
- SETTLE (2 cycles): ro_en = all ones; edges are not counted. This flushes the synchronisers.
- COUNT (WINDOW cycles): ro_en = all ones. cnt[i] increments on each detected edge of channel i and saturates at 2^CNT_W−1, with no wrap.
- COMPARE (RESP_W cycles): ro_en = 0. In cycle k, a = (base+k) mod NUM_RO and b = (base+k+1) mod NUM_RO. response[k] = 1 if cnt[a] > cnt[b], else 0, so ties give 0. Wrap from index NUM_RO−1 to 0 uses natural log2 truncation.
- DONE (1 cycle): done = 1, then return to IDLE.
- Counters keep their values after DONE until the next accepted start.
- Reset values: ro_en = 0, busy = 0, done = 0, response = 0, resp_mask = 0, all counters 0, synchronisers 0, FSM = IDLE.
- Reset asserted mid-operation aborts immediately to these values. No done is produced for the aborted request.

## Timing
- start is sampled at rising edge T.
- ro_en rises in the cycle after T, together with busy.
- The COUNT window covers cycles T+3 through T+2+WINDOW inclusive.
- COMPARE covers cycles T+3+WINDOW through T+2+WINDOW+RESP_W. ro_en is low from T+3+WINDOW.
- done is high in cycle T+3+WINDOW+RESP_W, so latency from the start edge to done is WINDOW+RESP_W+3 cycles.
- busy falls in the same cycle that done falls.
- response bits update one per COMPARE cycle. They are guaranteed stable only from the done cycle onward.
- start asserted in the cycle where done is high is ignored, because the FSM is not in IDLE. start in the following cycle is accepted.
- Edges arriving during SETTLE or COMPARE are not counted. An edge registered in the last COUNT cycle is counted.

## Configuration
- RO_PUF_TIE_MASK_EN defined:
  - Adds parameter THRESH (default 4) and output resp_mask.
  - In COMPARE cycle k, resp_mask[k] = 1 when |cnt[a] − cnt[b]| < THRESH, using a CNT_W-bit unsigned difference.
  - resp_mask resets to 0 and is held alongside response.
- RO_PUF_TIE_MASK_EN not defined: no THRESH, no resp_mask port, no difference logic; response behaviour is identical.

## Test plan
- Directed bench configuration: NUM_RO=4, CNT_W=16, WINDOW=64, RESP_W=4.
- Bench stimulus: ro_in[i] toggles every i+2 clk cycles, giving about 16/10/8/6 counted edges. challenge=0 → done at start+71 cycles; response=4'b0111; ro_en high for exactly 66 cycles.
- Same stimulus, challenge=3: pairs (3,0),(0,1),(1,2),(2,3) → response=4'b1110.
- ro_in[1] and ro_in[2] driven identically, challenge=1 → response[0]=0. With RO_PUF_TIE_MASK_EN, resp_mask[0]=1, and resp_mask is 0 for well-separated pairs.
- CNT_W=4 with ro_in[0] toggling every cycle → cnt[0] holds at 15 (no wrap) and response[0] follows the saturated compare.
- start pulsed again 10 cycles after an accepted start → ignored: a single done at start+71 and challenge unchanged.
- rst asserted during COUNT → ro_en, busy, done and response go to 0 immediately with no done pulse. A start after reset release completes normally.
